supernova_mdu_arbiter: RTL and testbench
========================================

Name: supernova_mdu_arbiter

Overview:
- Shares the single multi-cycle MDU (RV64M) among NUM_REQ issue sources, e.g. the integer reservation-station ports of several clusters.
- Grants round-robin and registers the winning rs_entry_t into an issue buffer.
- Holds the MDU request until accepted, tracks the one outstanding operation, and tags the MDU writeback with the source index.
- Handles pipeline flush by dropping or draining the in-flight operation, and includes a watchdog on MDU latency.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- SRC_W, $clog2(NUM_REQ), width of the source index.
- TIMEOUT_CYCLES, 64, maximum cycles in BUSY before timeout_err_out is set.

Ports:
- clk  in  1  core clock
- rst  in  1  asynchronous reset, active-high
- req_valid_in  in  NUM_REQ  per-source request valid
- req_entry_in  in  NUM_REQ x rs_entry_t  per-source instruction and operands
- req_ready_out  out  NUM_REQ  one-hot grant; handshake when valid & ready
- flush_in  in  1  kill any operation that has not yet written back
- mdu_req_valid_out  out  1  to MDU req_valid_in
- mdu_req_entry_out  out  rs_entry_t  registered issue entry
- mdu_req_ready_in  in  1  from MDU req_ready_out
- mdu_wb_valid_in  in  1  MDU writeback valid
- mdu_wb_data_in  in  XLEN  MDU result
- mdu_wb_gpr_tag_in  in  GPR_TAG_WIDTH  MDU physical destination tag
- mdu_wb_rob_idx_in  in  ROB_IDX_WIDTH  MDU ROB index
- mdu_wb_exception_in  in  1  MDU exception flag
- mdu_wb_trap_cause_in  in  ADDR_WIDTH  MDU trap cause
- wb_valid_out  out  1  writeback to CDB
- wb_data_out  out  XLEN  result to CDB
- wb_gpr_tag_out  out  GPR_TAG_WIDTH  destination tag to CDB
- wb_rob_idx_out  out  ROB_IDX_WIDTH  ROB index to CDB
- wb_exception_out  out  1  exception flag to CDB
- wb_trap_cause_out  out  ADDR_WIDTH  trap cause to CDB
- wb_src_out  out  SRC_W  source that issued the completed operation
- busy_out  out  1  state != IDLE
- timeout_err_out  out  1  sticky watchdog error

Behaviour:
- Reset (asynchronous, rst=1):
  - state=IDLE, rr_ptr=0, src_reg=0, wd_cnt=0, issue entry cleared.
  - All outputs 0.
- States: IDLE, ISSUE, BUSY, DRAIN.
- IDLE:
  - Grant the first valid source scanning from rr_ptr upward, wrapping modulo NUM_REQ.
  - req_ready_out is combinational and one-hot on the winner only; all zero if no request or flush_in=1.
  - On grant: capture the entry and src_reg, set rr_ptr=(winner+1) mod NUM_REQ, go to ISSUE.
- ISSUE:
  - mdu_req_valid_out=1 with the registered entry.
  - If flush_in=1: deassert valid, go to IDLE. The MDU never saw the op.
  - Else if mdu_req_ready_in=1: go to BUSY and clear wd_cnt.
  - Flush takes priority over a same-cycle MDU accept. Implementation gates mdu_req_valid_out with !flush_in.
- BUSY:
  - wd_cnt increments each cycle, saturating.
  - On mdu_wb_valid_in: drive the wb_* outputs combinationally from the mdu_wb_* inputs, set wb_src_out=src_reg, wb_valid_out=1, go to IDLE.
  - If flush_in=1 in the same cycle as mdu_wb_valid_in: suppress wb_valid_out, go to IDLE.
  - flush_in without mdu_wb_valid_in: go to DRAIN.
- DRAIN:
  - No grants. Wait for mdu_wb_valid_in and discard it (wb_valid_out=0), then go to IDLE.
  - Watchdog still counts.
- Writeback outside BUSY:
  - mdu_wb_valid_in in IDLE or ISSUE is ignored.
  - In these states wb_valid_out is never asserted.
- Watchdog: timeout_err_out is set when wd_cnt reaches TIMEOUT_CYCLES. It is sticky and cleared only by rst.
- Throughput and latency:
  - At most one outstanding op.
  - Accept-to-MDU latency is 1 cycle.
  - A new grant is possible the cycle after the writeback.
- Reset mid-operation: all state is discarded immediately, and any pending MDU writeback is ignored because state is IDLE.

Optional Feature:
- Macro: SUPERNOVA_MDU_ARB_PERF_EN.
- When defined, adds:
  - Ports grant_cnt_out[NUM_REQ] x 32, one per source.
  - Port stall_cnt_out, 32 bits.
- grant_cnt[i] increments on each grant to source i.
- stall_cnt increments each cycle that any req_valid_in=1 and no grant occurs.
- Both counters wrap modulo 2^32 and reset to 0.
- When undefined, neither the ports nor the logic exist.

Decomposition:
- In supernova_pkg:
  - typedef mdu_arb_state_t.
  - Constant MDU_ARB_MAX_REQ=8.
- Sub-module supernova_rr_arbiter (parameter N): inputs req vector and rr_ptr, outputs a one-hot grant and an index. It is reusable by other shared units.

Test Plan:
- Single source: src 2 issues MUL 3*5 with MDU stub latency 3 -> mdu_req_valid_out one cycle after accept; wb_valid_out with data=15, wb_src_out=2; busy_out returns 0.
- Fairness: all 4 sources valid continuously from reset -> grant order 0,1,2,3,0; no source waits more than 3 grants.
- ISSUE stall: hold mdu_req_ready_in=0 for 5 cycles -> mdu_req_valid_out stays 1 with a stable entry; all req_ready_out=0 throughout.
- Flush in BUSY before writeback: MDU wb arrives 4 cycles later -> state goes to DRAIN; wb_valid_out stays 0; next grant happens the cycle after the discarded wb.
- Flush coincident with mdu_wb_valid_in, and flush in ISSUE -> no wb_valid_out; IDLE next cycle; MDU receives no valid in the ISSUE case.
- Watchdog: stub never writes back -> timeout_err_out=1 after 64 BUSY cycles; it remains 1 until rst pulses.

Source files
------------

// File: rtl/supernova_pkg.sv
// -----------------------------------------------------------------------------
// supernova_pkg
// Shared types and constants for the supernova core slice that arbitrates the
// multi-cycle MDU (RV64M). Holds the reservation-station entry layout, the MDU
// arbiter state encoding and a round-robin pointer helper.
// -----------------------------------------------------------------------------
package supernova_pkg;

  localparam int XLEN            = 64;
  localparam int GPR_TAG_WIDTH   = 7;
  localparam int ROB_IDX_WIDTH   = 6;
  localparam int ADDR_WIDTH      = 64;
  localparam int MDU_ARB_MAX_REQ = 8;

  typedef enum logic [2:0] {
    MDU_MUL, MDU_MULH, MDU_MULHSU, MDU_MULHU,
    MDU_DIV, MDU_DIVU, MDU_REM,    MDU_REMU
  } mdu_op_t;

  typedef struct packed {
    mdu_op_t                  op;
    logic                     is_word;   // *W variants (32-bit result, sign-extended)
    logic [XLEN-1:0]          rs1_val;
    logic [XLEN-1:0]          rs2_val;
    logic [GPR_TAG_WIDTH-1:0] gpr_tag;
    logic [ROB_IDX_WIDTH-1:0] rob_idx;
  } rs_entry_t;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_ISSUE,
    ARB_BUSY,
    ARB_DRAIN
  } mdu_arb_state_t;

  // Index following idx, wrapping modulo n (n need not be a power of two).
  function automatic int rr_next(input int idx, input int n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/supernova_mdu_arbiter_if.sv
// -----------------------------------------------------------------------------
// supernova_mdu_arbiter_if
// Bundles the request, MDU issue and writeback buses of the MDU arbiter.
//   master : issue sources / MDU / CDB side (drives requests, MDU responses)
//   slave  : the arbiter (drives grants, MDU request, CDB writeback)
// Parameter NUM_REQ : number of request sources.
// -----------------------------------------------------------------------------
interface supernova_mdu_arbiter_if
  import supernova_pkg::*;
#(
  parameter int NUM_REQ = 4
);
  localparam int SRC_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  // request side
  logic [NUM_REQ-1:0]       req_valid_in;
  rs_entry_t [NUM_REQ-1:0]  req_entry_in;
  logic [NUM_REQ-1:0]       req_ready_out;

  // MDU issue side
  logic                     mdu_req_valid_out;
  rs_entry_t                mdu_req_entry_out;
  logic                     mdu_req_ready_in;

  // MDU writeback side
  logic                     mdu_wb_valid_in;
  logic [XLEN-1:0]          mdu_wb_data_in;
  logic [GPR_TAG_WIDTH-1:0] mdu_wb_gpr_tag_in;
  logic [ROB_IDX_WIDTH-1:0] mdu_wb_rob_idx_in;
  logic                     mdu_wb_exception_in;
  logic [ADDR_WIDTH-1:0]    mdu_wb_trap_cause_in;

  // CDB side
  logic                     wb_valid_out;
  logic [XLEN-1:0]          wb_data_out;
  logic [GPR_TAG_WIDTH-1:0] wb_gpr_tag_out;
  logic [ROB_IDX_WIDTH-1:0] wb_rob_idx_out;
  logic                     wb_exception_out;
  logic [ADDR_WIDTH-1:0]    wb_trap_cause_out;
  logic [SRC_W-1:0]         wb_src_out;

  modport master (
    output req_valid_in, req_entry_in, mdu_req_ready_in,
           mdu_wb_valid_in, mdu_wb_data_in, mdu_wb_gpr_tag_in,
           mdu_wb_rob_idx_in, mdu_wb_exception_in, mdu_wb_trap_cause_in,
    input  req_ready_out, mdu_req_valid_out, mdu_req_entry_out,
           wb_valid_out, wb_data_out, wb_gpr_tag_out, wb_rob_idx_out,
           wb_exception_out, wb_trap_cause_out, wb_src_out
  );

  modport slave (
    input  req_valid_in, req_entry_in, mdu_req_ready_in,
           mdu_wb_valid_in, mdu_wb_data_in, mdu_wb_gpr_tag_in,
           mdu_wb_rob_idx_in, mdu_wb_exception_in, mdu_wb_trap_cause_in,
    output req_ready_out, mdu_req_valid_out, mdu_req_entry_out,
           wb_valid_out, wb_data_out, wb_gpr_tag_out, wb_rob_idx_out,
           wb_exception_out, wb_trap_cause_out, wb_src_out
  );

endinterface

// File: rtl/supernova_rr_arbiter.sv
// -----------------------------------------------------------------------------
// supernova_rr_arbiter
// Combinational round-robin picker: grants the first set bit of i_req scanning
// upward from i_ptr, wrapping modulo N. Reusable by any shared unit.
// Ports:
//   i_req  [N]  request vector
//   i_ptr  [W]  highest-priority index this cycle
//   o_gnt  [N]  one-hot grant (zero when no request)
//   o_idx  [W]  index of the granted request
//   o_any       at least one request present
// -----------------------------------------------------------------------------
module supernova_rr_arbiter #(
  parameter int N = 4,
  parameter int W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0] i_req,
  input  logic [W-1:0] i_ptr,
  output logic [N-1:0] o_gnt,
  output logic [W-1:0] o_idx,
  output logic         o_any
);

  logic [W-1:0] w_cand;

  // Scan from the lowest priority down so the highest-priority hit is the
  // last one written.
  always_comb begin
    w_cand = '0;
    o_gnt  = '0;
    o_idx  = '0;
    o_any  = 1'b0;
    for (int k = N - 1; k >= 0; k--) begin
      w_cand = W'((int'(i_ptr) + k) % N);
      if (i_req[w_cand]) begin
        o_gnt         = '0;
        o_gnt[w_cand] = 1'b1;
        o_idx         = w_cand;
        o_any         = 1'b1;
      end
    end
  end

endmodule

// File: rtl/supernova_mdu_arbiter.sv
// -----------------------------------------------------------------------------
// supernova_mdu_arbiter
// Shares one multi-cycle MDU among NUM_REQ issue sources. Round-robin grant,
// registered issue entry, one outstanding op, writeback tagged with source,
// flush drop/drain and a sticky latency watchdog.
//
// Ports:
//   clk, rst         core clock, asynchronous active-high reset
//   flush_in         kill any op that has not yet written back
//   bus (slave)      request / MDU issue / MDU writeback / CDB writeback
//   busy_out         arbiter not idle
//   timeout_err_out  sticky watchdog error
//   grant_cnt_out, stall_cnt_out   perf counters (SUPERNOVA_MDU_ARB_PERF_EN)
//
// Optional feature macro: SUPERNOVA_MDU_ARB_PERF_EN
//
// state | meaning
// IDLE  | no op held; grant the round-robin winner
// ISSUE | registered entry presented to the MDU, waiting for accept
// BUSY  | MDU owns the op; waiting for writeback
// DRAIN | op flushed after MDU accept; swallow its writeback
// -----------------------------------------------------------------------------
module supernova_mdu_arbiter
  import supernova_pkg::*;
#(
  parameter int NUM_REQ        = 4,
  parameter int SRC_W          = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush_in,
  supernova_mdu_arbiter_if.slave bus,
  output logic                  busy_out,
  output logic                  timeout_err_out
`ifdef SUPERNOVA_MDU_ARB_PERF_EN
  ,
  output logic [31:0]           grant_cnt_out [NUM_REQ],
  output logic [31:0]           stall_cnt_out
`endif
);

  localparam int              WD_W   = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WD_W-1:0] WD_MAX = WD_W'(TIMEOUT_CYCLES);

  if (NUM_REQ < 2 || NUM_REQ > MDU_ARB_MAX_REQ) begin : g_num_req_check
    $error("supernova_mdu_arbiter: NUM_REQ out of range");
  end

  mdu_arb_state_t     r_state;
  mdu_arb_state_t     w_state_nxt;
  logic [SRC_W-1:0]   r_rr_ptr;
  logic [SRC_W-1:0]   r_src;
  rs_entry_t          r_entry;
  logic [WD_W-1:0]    r_wd_cnt;
  logic               r_timeout;

  logic [NUM_REQ-1:0] w_gnt;
  logic [SRC_W-1:0]   w_win_idx;
  logic               w_win_any;
  logic               w_grant_en;
  logic               w_grant_fire;
  logic               w_issue_accept;
  logic               w_wb_fire;
  logic               w_wd_run;

  supernova_rr_arbiter #(
    .N (NUM_REQ),
    .W (SRC_W)
  ) u_rr (
    .i_req (bus.req_valid_in),
    .i_ptr (r_rr_ptr),
    .o_gnt (w_gnt),
    .o_idx (w_win_idx),
    .o_any (w_win_any)
  );

  // rst is folded in so grants stay low while reset is held.
  assign w_grant_en     = (r_state == ARB_IDLE) && !flush_in && !rst;
  assign w_grant_fire   = w_grant_en && w_win_any;
  assign w_issue_accept = (r_state == ARB_ISSUE) && !flush_in && bus.mdu_req_ready_in;
  assign w_wb_fire      = (r_state == ARB_BUSY) && bus.mdu_wb_valid_in && !flush_in;
  assign w_wd_run       = (r_state == ARB_BUSY) || (r_state == ARB_DRAIN);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ARB_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt           = r_state;
    bus.req_ready_out     = '0;
    bus.mdu_req_valid_out = 1'b0;
    bus.wb_valid_out      = 1'b0;
    case (r_state)
      ARB_IDLE: begin
        bus.req_ready_out = w_grant_en ? w_gnt : '0;
        if (w_grant_fire) w_state_nxt = ARB_ISSUE;
      end
      ARB_ISSUE: begin
        // A flush wins over a same-cycle accept: the MDU never sees valid.
        if (flush_in) begin
          w_state_nxt = ARB_IDLE;
        end else begin
          bus.mdu_req_valid_out = 1'b1;
          if (bus.mdu_req_ready_in) w_state_nxt = ARB_BUSY;
        end
      end
      ARB_BUSY: begin
        if (bus.mdu_wb_valid_in) begin
          bus.wb_valid_out = !flush_in;
          w_state_nxt      = ARB_IDLE;
        end else if (flush_in) begin
          w_state_nxt = ARB_DRAIN;
        end
      end
      ARB_DRAIN: begin
        if (bus.mdu_wb_valid_in) w_state_nxt = ARB_IDLE;
      end
      default: w_state_nxt = ARB_IDLE;
    endcase
  end

  // Payload is zeroed whenever no writeback is forwarded.
  assign bus.wb_data_out       = w_wb_fire ? bus.mdu_wb_data_in       : '0;
  assign bus.wb_gpr_tag_out    = w_wb_fire ? bus.mdu_wb_gpr_tag_in    : '0;
  assign bus.wb_rob_idx_out    = w_wb_fire ? bus.mdu_wb_rob_idx_in    : '0;
  assign bus.wb_exception_out  = w_wb_fire ? bus.mdu_wb_exception_in  : 1'b0;
  assign bus.wb_trap_cause_out = w_wb_fire ? bus.mdu_wb_trap_cause_in : '0;
  assign bus.wb_src_out        = w_wb_fire ? r_src                    : '0;

  assign bus.mdu_req_entry_out = r_entry;
  assign busy_out              = (r_state != ARB_IDLE);
  assign timeout_err_out       = r_timeout;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rr_ptr  <= '0;
      r_src     <= '0;
      r_entry   <= '0;
      r_wd_cnt  <= '0;
      r_timeout <= 1'b0;
    end else begin
      if (w_grant_fire) begin
        r_entry  <= bus.req_entry_in[w_win_idx];
        r_src    <= w_win_idx;
        r_rr_ptr <= SRC_W'(rr_next(int'(w_win_idx), NUM_REQ));
      end
      if (w_issue_accept)
        r_wd_cnt <= '0;
      else if (w_wd_run && r_wd_cnt != WD_MAX)
        r_wd_cnt <= r_wd_cnt + 1'b1;
      // Set on the same edge the counter reaches the limit.
      if (w_wd_run && r_wd_cnt >= WD_MAX - 1'b1)
        r_timeout <= 1'b1;
    end
  end

`ifdef SUPERNOVA_MDU_ARB_PERF_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_REQ; i++) grant_cnt_out[i] <= '0;
      stall_cnt_out <= '0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (w_grant_fire && w_win_idx == SRC_W'(i))
          grant_cnt_out[i] <= grant_cnt_out[i] + 32'd1;
      end
      if ((|bus.req_valid_in) && !w_grant_fire)
        stall_cnt_out <= stall_cnt_out + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_supernova_mdu_arbiter.sv
module tb_supernova_mdu_arbiter;
  import supernova_pkg::*;

  localparam int NUM_REQ = 4;
  localparam int SRC_W   = 2;

  typedef struct {
    logic [XLEN-1:0]          data;
    logic [SRC_W-1:0]         src;
    logic [GPR_TAG_WIDTH-1:0] tag;
    logic [ROB_IDX_WIDTH-1:0] rob;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  logic flush_in;
  logic busy_out;
  logic timeout_err_out;
`ifdef SUPERNOVA_MDU_ARB_PERF_EN
  logic [31:0] grant_cnt [NUM_REQ];
  logic [31:0] stall_cnt;
`endif

  supernova_mdu_arbiter_if #(.NUM_REQ(NUM_REQ)) bus ();

  supernova_mdu_arbiter #(
    .NUM_REQ        (NUM_REQ),
    .SRC_W          (SRC_W),
    .TIMEOUT_CYCLES (64)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .flush_in        (flush_in),
    .bus             (bus),
    .busy_out        (busy_out),
    .timeout_err_out (timeout_err_out)
`ifdef SUPERNOVA_MDU_ARB_PERF_EN
    ,
    .grant_cnt_out   (grant_cnt),
    .stall_cnt_out   (stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  exp_t      sb_q[$];
  rs_entry_t ent [NUM_REQ];
  int        n_cmp = 0;
  int        n_err = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    flush_in                 = 1'b0;
    bus.req_valid_in         = '0;
    bus.mdu_req_ready_in     = 1'b0;
    bus.mdu_wb_valid_in      = 1'b0;
    bus.mdu_wb_data_in       = '0;
    bus.mdu_wb_gpr_tag_in    = '0;
    bus.mdu_wb_rob_idx_in    = '0;
    bus.mdu_wb_exception_in  = 1'b0;
    bus.mdu_wb_trap_cause_in = '0;
  endtask

  task automatic set_entries();
    for (int i = 0; i < NUM_REQ; i++) begin
      ent[i]         = '0;
      ent[i].op      = MDU_MUL;
      ent[i].rs1_val = XLEN'(10 + i);
      ent[i].rs2_val = XLEN'(100 + 3 * i);
      ent[i].gpr_tag = GPR_TAG_WIDTH'(8 + i);
      ent[i].rob_idx = ROB_IDX_WIDTH'(20 + i);
    end
    ent[2].rs1_val = 64'd3;
    ent[2].rs2_val = 64'd5;
    for (int i = 0; i < NUM_REQ; i++) bus.req_entry_in[i] = ent[i];
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    idle_inputs();
    tick();
    tick();
    rst = 1'b0;
    #1;
  endtask

  // Stub MDU returns rs1*rs2 of whatever entry it was handed.
  task automatic get_to_busy(input int src);
    bus.req_valid_in      = '0;
    bus.req_valid_in[src] = 1'b1;
    #1;
    tick();
    bus.req_valid_in     = '0;
    bus.mdu_req_ready_in = 1'b1;
    tick();
    bus.mdu_req_ready_in = 1'b0;
  endtask

  // One op from grant to writeback, MDU stalled 'stall' cycles, latency 'lat'.
  task automatic do_op(input int exp_src, input int stall, input int lat, input string nm);
    rs_entry_t          e;
    exp_t               x;
    exp_t               y;
    logic [NUM_REQ-1:0] exp_gnt;
    e       = '0;
    exp_gnt = '0;
    exp_gnt[exp_src] = 1'b1;
    #1;
    n_cmp++; if (bus.req_ready_out !== exp_gnt) begin n_err++; $display("FAIL %s_grant: got %b expected %b", nm, bus.req_ready_out, exp_gnt); end
    x.data = ent[exp_src].rs1_val * ent[exp_src].rs2_val;
    x.src  = SRC_W'(exp_src);
    x.tag  = ent[exp_src].gpr_tag;
    x.rob  = ent[exp_src].rob_idx;
    sb_q.push_back(x);
    bus.mdu_req_ready_in = 1'b0;
    tick();
    for (int s = 0; s <= stall; s++) begin
      if (s == stall) bus.mdu_req_ready_in = 1'b1;
      #1;
      n_cmp++; if (bus.mdu_req_valid_out !== 1'b1) begin n_err++; $display("FAIL %s_mdu_valid: got %b expected 1 (cycle %0d)", nm, bus.mdu_req_valid_out, s); end
      n_cmp++; if (bus.mdu_req_entry_out !== ent[exp_src]) begin n_err++; $display("FAIL %s_mdu_entry: got %h expected %h", nm, bus.mdu_req_entry_out, ent[exp_src]); end
      n_cmp++; if (bus.req_ready_out !== '0) begin n_err++; $display("FAIL %s_no_grant_issue: got %b expected 0", nm, bus.req_ready_out); end
      e = bus.mdu_req_entry_out;
      tick();
    end
    bus.mdu_req_ready_in = 1'b0;
    for (int l = 1; l < lat; l++) begin
      #1;
      n_cmp++; if (bus.wb_valid_out !== 1'b0) begin n_err++; $display("FAIL %s_early_wb: got %b expected 0", nm, bus.wb_valid_out); end
      tick();
    end
    bus.mdu_wb_valid_in   = 1'b1;
    bus.mdu_wb_data_in    = e.rs1_val * e.rs2_val;
    bus.mdu_wb_gpr_tag_in = e.gpr_tag;
    bus.mdu_wb_rob_idx_in = e.rob_idx;
    #1;
    n_cmp++; if (bus.wb_valid_out !== 1'b1) begin n_err++; $display("FAIL %s_wb_valid: got %b expected 1", nm, bus.wb_valid_out); end
    if (sb_q.size() == 0) begin
      n_cmp++; n_err++; $display("FAIL %s_sb_empty: got empty queue expected an entry", nm);
    end else begin
      y = sb_q.pop_front();
      n_cmp++; if (bus.wb_data_out !== y.data) begin n_err++; $display("FAIL %s_wb_data: got %0d expected %0d", nm, bus.wb_data_out, y.data); end
      n_cmp++; if (bus.wb_src_out !== y.src) begin n_err++; $display("FAIL %s_wb_src: got %0d expected %0d", nm, bus.wb_src_out, y.src); end
      n_cmp++; if (bus.wb_gpr_tag_out !== y.tag) begin n_err++; $display("FAIL %s_wb_tag: got %0d expected %0d", nm, bus.wb_gpr_tag_out, y.tag); end
      n_cmp++; if (bus.wb_rob_idx_out !== y.rob) begin n_err++; $display("FAIL %s_wb_rob: got %0d expected %0d", nm, bus.wb_rob_idx_out, y.rob); end
    end
    tick();
    bus.mdu_wb_valid_in = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle_inputs();
    set_entries();
    bus.req_valid_in = 4'hF;
    tick();
    n_cmp++; if (bus.req_ready_out !== 4'h0) begin n_err++; $display("FAIL reset_req_ready: got %b expected 0000", bus.req_ready_out); end
    n_cmp++; if (bus.mdu_req_valid_out !== 1'b0) begin n_err++; $display("FAIL reset_mdu_valid: got %b expected 0", bus.mdu_req_valid_out); end
    n_cmp++; if (bus.mdu_req_entry_out !== '0) begin n_err++; $display("FAIL reset_mdu_entry: got %h expected 0", bus.mdu_req_entry_out); end
    n_cmp++; if (bus.wb_valid_out !== 1'b0) begin n_err++; $display("FAIL reset_wb_valid: got %b expected 0", bus.wb_valid_out); end
    n_cmp++; if (bus.wb_src_out !== '0) begin n_err++; $display("FAIL reset_wb_src: got %0d expected 0", bus.wb_src_out); end
    n_cmp++; if (busy_out !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b expected 0", busy_out); end
    n_cmp++; if (timeout_err_out !== 1'b0) begin n_err++; $display("FAIL reset_timeout: got %b expected 0", timeout_err_out); end
    bus.req_valid_in = '0;
    tick();
    rst = 1'b0;
    #1;
  endtask

  task automatic test_single();
    bus.req_valid_in = 4'b0100;
    do_op(2, 0, 3, "single");
    bus.req_valid_in = '0;
    #1;
    n_cmp++; if (busy_out !== 1'b0) begin n_err++; $display("FAIL single_busy_end: got %b expected 0", busy_out); end
  endtask

  task automatic test_fairness();
    int order [5] = '{0, 1, 2, 3, 0};
    apply_reset();
    set_entries();
    bus.req_valid_in = 4'hF;
    for (int k = 0; k < 5; k++) do_op(order[k], 0, 2, "rr");
    bus.req_valid_in = '0;
  endtask

  task automatic test_sparse();
    bus.req_valid_in = 4'b1010;
    do_op(1, 0, 1, "sparse_a");
    do_op(3, 0, 2, "sparse_b");
    do_op(1, 0, 1, "sparse_c");
    bus.req_valid_in = 4'b0001;
    do_op(0, 0, 2, "wrap");
    bus.req_valid_in = '0;
  endtask

  task automatic test_issue_stall();
    bus.req_valid_in = 4'hF;
    do_op(1, 5, 3, "stall");
    bus.req_valid_in = '0;
  endtask

  task automatic test_flush_busy();
    get_to_busy(2);
    flush_in = 1'b1;
    #1;
    n_cmp++; if (bus.wb_valid_out !== 1'b0) begin n_err++; $display("FAIL flush_busy_wb: got %b expected 0", bus.wb_valid_out); end
    tick();
    flush_in         = 1'b0;
    bus.req_valid_in = 4'b0001;
    for (int d = 0; d < 3; d++) begin
      #1;
      n_cmp++; if (bus.req_ready_out !== 4'h0) begin n_err++; $display("FAIL drain_no_grant: got %b expected 0000", bus.req_ready_out); end
      n_cmp++; if (busy_out !== 1'b1) begin n_err++; $display("FAIL drain_busy: got %b expected 1", busy_out); end
      tick();
    end
    bus.mdu_wb_valid_in = 1'b1;
    bus.mdu_wb_data_in  = 64'hDEAD;
    #1;
    n_cmp++; if (bus.wb_valid_out !== 1'b0) begin n_err++; $display("FAIL drain_wb_discard: got %b expected 0", bus.wb_valid_out); end
    n_cmp++; if (bus.req_ready_out !== 4'h0) begin n_err++; $display("FAIL drain_wb_no_grant: got %b expected 0000", bus.req_ready_out); end
    tick();
    bus.mdu_wb_valid_in = 1'b0;
    #1;
    n_cmp++; if (bus.req_ready_out !== 4'b0001) begin n_err++; $display("FAIL post_drain_grant: got %b expected 0001", bus.req_ready_out); end
    do_op(0, 0, 1, "post_drain");
    bus.req_valid_in = '0;
  endtask

  task automatic test_flush_coincident();
    get_to_busy(3);
    tick();
    bus.mdu_wb_valid_in = 1'b1;
    bus.mdu_wb_data_in  = 64'd77;
    flush_in            = 1'b1;
    #1;
    n_cmp++; if (bus.wb_valid_out !== 1'b0) begin n_err++; $display("FAIL flush_coinc_wb: got %b expected 0", bus.wb_valid_out); end
    tick();
    bus.mdu_wb_valid_in = 1'b0;
    flush_in            = 1'b0;
    #1;
    n_cmp++; if (busy_out !== 1'b0) begin n_err++; $display("FAIL flush_coinc_idle: got %b expected 0", busy_out); end
  endtask

  task automatic test_flush_issue();
    bus.req_valid_in = 4'b0010;
    #1;
    tick();
    bus.req_valid_in     = '0;
    bus.mdu_req_ready_in = 1'b1;
    bus.mdu_wb_valid_in  = 1'b1;
    flush_in             = 1'b1;
    #1;
    n_cmp++; if (bus.mdu_req_valid_out !== 1'b0) begin n_err++; $display("FAIL flush_issue_mdu_valid: got %b expected 0", bus.mdu_req_valid_out); end
    n_cmp++; if (bus.wb_valid_out !== 1'b0) begin n_err++; $display("FAIL flush_issue_wb: got %b expected 0", bus.wb_valid_out); end
    n_cmp++; if (busy_out !== 1'b1) begin n_err++; $display("FAIL flush_issue_busy: got %b expected 1", busy_out); end
    tick();
    flush_in             = 1'b0;
    bus.mdu_req_ready_in = 1'b0;
    #1;
    n_cmp++; if (busy_out !== 1'b0) begin n_err++; $display("FAIL flush_issue_idle: got %b expected 0", busy_out); end
    n_cmp++; if (bus.mdu_req_valid_out !== 1'b0) begin n_err++; $display("FAIL flush_issue_mdu_after: got %b expected 0", bus.mdu_req_valid_out); end
    n_cmp++; if (bus.wb_valid_out !== 1'b0) begin n_err++; $display("FAIL idle_stray_wb: got %b expected 0", bus.wb_valid_out); end
    bus.mdu_wb_valid_in = 1'b0;
  endtask

  task automatic test_watchdog();
    get_to_busy(2);
    repeat (63) tick();
    #1;
    n_cmp++; if (timeout_err_out !== 1'b0) begin n_err++; $display("FAIL wd_before_limit: got %b expected 0", timeout_err_out); end
    tick();
    #1;
    n_cmp++; if (timeout_err_out !== 1'b1) begin n_err++; $display("FAIL wd_at_limit: got %b expected 1", timeout_err_out); end
    flush_in = 1'b1;
    tick();
    flush_in = 1'b0;
    repeat (20) tick();
    n_cmp++; if (timeout_err_out !== 1'b1) begin n_err++; $display("FAIL wd_sticky: got %b expected 1", timeout_err_out); end
    n_cmp++; if (busy_out !== 1'b1) begin n_err++; $display("FAIL wd_drain_busy: got %b expected 1", busy_out); end
    rst = 1'b1;
    #2;
    n_cmp++; if (timeout_err_out !== 1'b0) begin n_err++; $display("FAIL wd_async_clear: got %b expected 0", timeout_err_out); end
    n_cmp++; if (busy_out !== 1'b0) begin n_err++; $display("FAIL rst_mid_op_busy: got %b expected 0", busy_out); end
    tick();
    rst                 = 1'b0;
    bus.mdu_wb_valid_in = 1'b1;
    #1;
    n_cmp++; if (bus.wb_valid_out !== 1'b0) begin n_err++; $display("FAIL rst_stale_wb: got %b expected 0", bus.wb_valid_out); end
    tick();
    bus.mdu_wb_valid_in = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "global timeout");
  end

  initial begin
    test_reset();
    test_single();
    test_fairness();
    test_sparse();
    test_issue_stall();
    test_flush_busy();
    test_flush_coincident();
    test_flush_issue();
    test_watchdog();
    n_cmp++; if (sb_q.size() != 0) begin n_err++; $display("FAIL sb_leftover: got %0d entries expected 0", sb_q.size()); end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
